core_sequencer: RTL and testbench

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/core_sequencer.sv | 167 ++++++++++++++++
 tb/tb_core_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control sequencer: fetch/decode/execute/memory/writeback
// with bounded wait on memory handshakes and sticky halt on error.
module core_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_sel,
  output logic        reg_write,
  output logic        instr_retired,
  output logic [31:0] retire_count,
  output logic        halted,
  output logic [1:0]  err_code,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
  } cls_t;

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           cur_state, nxt_state;
  cls_t             cls_q, cls_nxt;
  logic [CNT_W-1:0] wait_cnt, cnt_nxt;
  logic [1:0]       err_q, err_nxt;
  logic             timeout_hit;

  function automatic cls_t decode_class(input logic [6:0] op);
    case (op)
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b1100011: return C_BRANCH;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      default:    return C_NONE;
    endcase
  endfunction

  // The last permitted wait cycle: an ack here still wins over the timeout.
  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == CNT_LAST);

  always_comb begin
    nxt_state     = cur_state;
    cls_nxt       = cls_q;
    cnt_nxt       = wait_cnt;
    err_nxt       = err_q;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_sel        = 1'b0;
    reg_write     = 1'b0;
    instr_retired = 1'b0;
    halted        = 1'b0;
    case (cur_state)
      S_IDLE: begin
        nxt_state = S_FETCH;
        cnt_nxt   = '0;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write  = 1'b1;
          nxt_state = S_DECODE;
        end else if (timeout_hit) begin
          nxt_state = S_HALT;
          err_nxt   = 2'b10;
        end else begin
          cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      S_DECODE: begin
        cls_nxt = decode_class(opcode);
        if (cls_nxt == C_NONE) begin
          nxt_state = S_HALT;
          err_nxt   = 2'b01;
        end else begin
          nxt_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls_q == C_LOAD || cls_q == C_STORE) begin
          nxt_state = S_MEM;
          cnt_nxt   = '0;
        end else begin
          nxt_state = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_STORE);
        if (dmem_ack) begin
          if (cls_q == C_STORE) begin
            pc_write      = 1'b1;
            instr_retired = 1'b1;
            nxt_state     = S_FETCH;
            cnt_nxt       = '0;
          end else begin
            nxt_state = S_WB;
          end
        end else if (timeout_hit) begin
          nxt_state = S_HALT;
          err_nxt   = 2'b11;
        end else begin
          cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      S_WB: begin
        pc_write      = 1'b1;
        instr_retired = 1'b1;
        reg_write     = (cls_q != C_BRANCH);
        pc_sel        = (cls_q == C_JAL) || (cls_q == C_JALR) ||
                        ((cls_q == C_BRANCH) && branch_taken);
        nxt_state     = S_FETCH;
        cnt_nxt       = '0;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        nxt_state = S_HALT;
        err_nxt   = 2'b01;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state    <= S_IDLE;
      cls_q        <= C_NONE;
      wait_cnt     <= '0;
      err_q        <= 2'b00;
      retire_count <= 32'd0;
    end else begin
      cur_state <= nxt_state;
      cls_q     <= cls_nxt;
      wait_cnt  <= cnt_nxt;
      err_q     <= err_nxt;
      if (instr_retired) retire_count <= retire_count + 32'd1;
    end
  end

  assign state    = cur_state;
  assign err_code = err_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer: per-instruction expected cycle traces
// are generated from the instruction's class and handshake delays.
module tb_core_sequencer;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic        branch_taken = 1'b0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_sel;
  logic        reg_write, instr_retired, halted;
  logic [31:0] retire_count;
  logic [1:0]  err_code;
  logic [2:0]  state;

  always #5 clk = ~clk;

  core_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_ack(dmem_ack), .ir_write(ir_write),
    .pc_write(pc_write), .pc_sel(pc_sel), .reg_write(reg_write),
    .instr_retired(instr_retired), .retire_count(retire_count),
    .halted(halted), .err_code(err_code), .state(state)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] exp_ret = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected vector: {imem_req,dmem_req,dmem_we,ir_write,pc_write,pc_sel,reg_write,instr_retired,halted,err[1:0],state[2:0]}
  typedef struct packed {
    logic        ia;
    logic        da;
    logic [13:0] ex;
  } cyc_t;
  cyc_t q[$];

  function automatic logic [13:0] pk(input logic [2:0] st, input logic ireq, input logic dreq,
                                     input logic we, input logic irw, input logic pcw,
                                     input logic psel, input logic rw, input logic ret,
                                     input logic hlt, input logic [1:0] err);
    return {ireq, dreq, we, irw, pcw, psel, rw, ret, hlt, err, st};
  endfunction

  function automatic void add(input logic ia, input logic da, input logic [13:0] ex);
    q.push_back(cyc_t'({ia, da, ex}));
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // 0 illegal, 1 plain register-writing, 2 load, 3 store, 4 branch, 5 jump
  function automatic int classify(input logic [6:0] op);
    case (op)
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return 4;
      7'b1101111, 7'b1100111: return 5;
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic build(input logic [6:0] op, input int fd, input int md, input logic bt,
                       output logic [1:0] herr);
    int c;
    herr = 2'b00;
    for (int i = 0; i < fd && i < TO; i++) add(1'b0, rb(), pk(3'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    if (fd >= TO) begin herr = 2'b10; return; end
    add(1'b1, rb(), pk(3'd1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00));
    add(rb(), rb(), pk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    c = classify(op);
    if (c == 0) begin herr = 2'b01; return; end
    add(rb(), rb(), pk(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    if (c == 2 || c == 3) begin
      for (int i = 0; i < md && i < TO; i++)
        add(rb(), 1'b0, pk(3'd4, 0, 1, c == 3, 0, 0, 0, 0, 0, 0, 2'b00));
      if (md >= TO) begin herr = 2'b11; return; end
      if (c == 3) begin
        add(rb(), 1'b1, pk(3'd4, 0, 1, 1, 0, 1, 0, 0, 1, 0, 2'b00));
        return;
      end
      add(rb(), 1'b1, pk(3'd4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    end
    add(rb(), rb(), pk(3'd5, 0, 0, 0, 0, 1, (c == 5) || (c == 4 && bt), c != 4, 1, 0, 2'b00));
  endtask

  task automatic run_q(input int n);
    int lim;
    lim = (n < 0) ? q.size() : n;
    for (int i = 0; i < lim; i++) begin
      imem_ack = q[i].ia;
      dmem_ack = q[i].da;
      @(negedge clk);
      check($sformatf("c%0d_st%0d_outputs", cyc, q[i].ex[2:0]),
            {18'd0, imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_sel, reg_write,
             instr_retired, halted, err_code, state},
            {18'd0, q[i].ex});
      check($sformatf("c%0d_retire_count", cyc), retire_count, exp_ret);
      if (q[i].ex[6]) exp_ret = exp_ret + 32'd1;
      @(posedge clk);
      #1;
      cyc++;
    end
    q.delete();
  endtask

  // Reset with optional late acks on the bus; the IDLE cycle that follows must ignore them.
  task automatic do_reset(input logic late);
    reset = 1'b1;
    imem_ack = late;
    dmem_ack = late;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_ret = 32'd0;
    add(late, late, pk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    run_q(-1);
  endtask

  task automatic exec_instr(input logic [6:0] op, input int fd, input int md, input logic bt);
    logic [1:0] herr;
    opcode = op;
    branch_taken = bt;
    build(op, fd, md, bt, herr);
    run_q(-1);
    if (herr != 2'b00) begin
      for (int i = 0; i < 4; i++) add(rb(), rb(), pk(3'd6, 0, 0, 0, 0, 0, 0, 0, 0, 1, herr));
      run_q(-1);
      do_reset(rb());
    end
  endtask

  typedef struct {
    logic [6:0] op;
    int         fd;
    int         md;
    logic       bt;
  } dir_t;

  dir_t dir[16] = '{
    '{7'b0110011, 0, 0, 1'b0},   // R-type, immediate fetch ack
    '{7'b0000011, 1, 3, 1'b0},   // load, ack on the last allowed wait cycle
    '{7'b0100011, 2, 1, 1'b0},   // store retires from MEM
    '{7'b1100011, 0, 0, 1'b1},   // branch taken
    '{7'b1100011, 1, 0, 1'b0},   // branch not taken
    '{7'b1101111, 0, 0, 1'b0},
    '{7'b1100111, 2, 0, 1'b1},
    '{7'b0110111, 0, 0, 1'b0},
    '{7'b0010111, 0, 0, 1'b1},
    '{7'b0010011, 3, 0, 1'b0},   // fetch ack coincides with timeout
    '{7'b0000000, 0, 0, 1'b0},   // illegal
    '{7'b0110001, 1, 0, 1'b0},   // low opcode bits not 11
    '{7'b0110011, 99, 0, 1'b0},  // fetch timeout
    '{7'b0100011, 0, 99, 1'b0},  // store data timeout
    '{7'b0000011, 0, 99, 1'b0},  // load data timeout
    '{7'b0100011, 0, 3, 1'b0}
  };

  logic [6:0] legal[9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  initial begin
    logic [1:0] herr;
    logic [6:0] op;
    int fd, md;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0);

    foreach (dir[i]) exec_instr(dir[i].op, dir[i].fd, dir[i].md, dir[i].bt);

    // Reset in the middle of a data access, with a late ack during reset.
    opcode = 7'b0000011;
    branch_taken = 1'b0;
    build(7'b0000011, 0, 3, 1'b0, herr);
    run_q(5);
    do_reset(1'b1);
    exec_instr(7'b0110011, 0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      else op = legal[$urandom_range(0, 8)];
      fd = ($urandom_range(0, 14) == 0) ? TO : $urandom_range(0, TO - 1);
      md = ($urandom_range(0, 14) == 0) ? TO : $urandom_range(0, TO - 1);
      exec_instr(op, fd, md, rb());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running expected=finished");
    $fatal(1, "bench watchdog expired");
  end

endmodule
